// File: rtl/kernel_mem_block.sv
// -----------------------------------------------------------------------------
// kernel_mem_block
//   Dual-port kernel coefficient store for the FFT-convolution datapath.
//   The host side writes half a tile (8 complex words) per cycle into one of
//   two sub-banks. The MAC side reads a full 4x4 tile (16 complex words) per
//   address with one cycle of latency.
//
//   Sub-bank 0 holds tile rows 0-1 (out_data lanes 0..7).
//   Sub-bank 1 holds tile rows 2-3 (out_data lanes 8..15).
//   Each lane is {real[CPLX_W-1:0], imag[CPLX_W-1:0]}, with real in the upper half.
//
// Ports
//   clk            : single rising-edge clock
//   reset          : synchronous, active-high; clears out_data, blocks writes
//   we             : write enable
//   select         : write target sub-bank (0 = rows 0-1, 1 = rows 2-3)
//   write_address  : write row
//   read_address   : read row
//   in_data        : 8 complex lanes written to the selected sub-bank
//   out_data       : 16 complex lanes, registered read of both sub-banks
//
// Configuration
//   KERNEL_MEM_WR_BYPASS_EN : when defined, a write and a read to the same
//   address in the same cycle forward in_data to the selected sub-bank's
//   lanes (write-first). When undefined, the read returns the old contents
//   (read-first), and no forwarding logic is built.
//
//   Storage is deliberately not reset. Coefficients loaded before a reset
//   survive it, and the array can map onto plain RAM macros.
// -----------------------------------------------------------------------------
module kernel_mem_block #(
  parameter int CPLX_W = 32,
  parameter int ADDR_W = 9
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic                     select,
  input  logic [ADDR_W-1:0]        write_address,
  input  logic [ADDR_W-1:0]        read_address,
  input  logic [8*2*CPLX_W-1:0]    in_data,
  output logic [16*2*CPLX_W-1:0]   out_data
);

  localparam int HALF_W = 8 * 2 * CPLX_W;
  localparam int OUT_W  = 2 * HALF_W;
  localparam int DEPTH  = 1 << ADDR_W;

  logic [HALF_W-1:0] bank0_q [DEPTH];
  logic [HALF_W-1:0] bank1_q [DEPTH];

  logic              wr0_s;
  logic              wr1_s;
  logic [HALF_W-1:0] rd0_s;
  logic [HALF_W-1:0] rd1_s;
  logic [OUT_W-1:0]  out_d;
  logic [OUT_W-1:0]  out_q;

  // A write reaches only the selected sub-bank, and reset cancels it.
  assign wr0_s = we & ~reset & ~select;
  assign wr1_s = we & ~reset &  select;

  // Sub-bank 0 storage (tile rows 0-1)
  always_ff @(posedge clk) begin
    if (wr0_s) begin
      bank0_q[write_address] <= in_data;
    end
  end

  // Sub-bank 1 storage (tile rows 2-3)
  always_ff @(posedge clk) begin
    if (wr1_s) begin
      bank1_q[write_address] <= in_data;
    end
  end

  // Asynchronous array read, captured by out_q below. This gives read-first
  // semantics because the array updates on the same edge.
  assign rd0_s = bank0_q[read_address];
  assign rd1_s = bank1_q[read_address];

`ifdef KERNEL_MEM_WR_BYPASS_EN
  logic hit_s;
  logic fwd0_s;
  logic fwd1_s;

  // A same-address write overrides only the lanes of the sub-bank it targets.
  assign hit_s  = we & (write_address == read_address);
  assign fwd0_s = hit_s & ~select;
  assign fwd1_s = hit_s &  select;

  // Next read data with write-first forwarding
  always_comb begin
    out_d = {OUT_W{1'b0}};
    out_d[HALF_W-1:0]     = fwd0_s ? in_data : rd0_s;
    out_d[OUT_W-1:HALF_W] = fwd1_s ? in_data : rd1_s;
  end
`else
  // Next read data, read-first
  always_comb begin
    out_d = {OUT_W{1'b0}};
    out_d = {rd1_s, rd0_s};
  end
`endif

  // Registered read port. It is cleared and held at zero during reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= {OUT_W{1'b0}};
    end else begin
      out_q <= out_d;
    end
  end

  assign out_data = out_q;

endmodule

// File: tb/tb_kernel_mem_block.sv
module tb_kernel_mem_block;

  logic          clk = 1'b0;
  logic          reset;
  logic          we;
  logic          select;
  logic [8:0]    write_address;
  logic [8:0]    read_address;
  logic [511:0]  in_data;
  logic [1023:0] out_data;

  int errors = 0;
  int checks = 0;

  kernel_mem_block #(.CPLX_W(32), .ADDR_W(9)) dut (
    .clk(clk), .reset(reset), .we(we), .select(select),
    .write_address(write_address), .read_address(read_address),
    .in_data(in_data), .out_data(out_data)
  );

  always #5 clk = ~clk;

  // Reference model: two arrays of half-tiles with per-row "written" flags,
  // because power-up contents are undefined.
  logic [511:0] m0 [512];
  logic [511:0] m1 [512];
  bit           v0 [512];
  bit           v1 [512];
  logic [511:0] e0, e1;
  bit           k0 = 1'b0, k1 = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        e0 = '0; e1 = '0; k0 = 1'b1; k1 = 1'b1;
      end else begin
        e0 = m0[read_address]; k0 = v0[read_address];
        e1 = m1[read_address]; k1 = v1[read_address];
`ifdef KERNEL_MEM_WR_BYPASS_EN
        if (we && write_address == read_address) begin
          if (select) begin e1 = in_data; k1 = 1'b1; end
          else        begin e0 = in_data; k0 = 1'b1; end
        end
`endif
        if (we) begin
          if (select) begin m1[write_address] = in_data; v1[write_address] = 1'b1; end
          else        begin m0[write_address] = in_data; v0[write_address] = 1'b1; end
        end
      end
    end
  end

  // Per-cycle comparison against the model, on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (k0) begin
        checks++;
        if (out_data[511:0] !== e0) begin
          errors++;
          $display("FAIL model_lo t=%0t got=%h exp=%h", $time, out_data[511:0], e0);
        end
      end
      if (k1) begin
        checks++;
        if (out_data[1023:512] !== e1) begin
          errors++;
          $display("FAIL model_hi t=%0t got=%h exp=%h", $time, out_data[1023:512], e1);
        end
      end
    end
  end

  task automatic lit(input string name, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Drive one cycle of inputs (called at a negedge), then wait for the next
  // negedge, where out_data reflects this cycle's read.
  task automatic step(input bit r, input bit w, input bit s, input logic [8:0] wa,
                      input logic [8:0] ra, input logic [511:0] d);
    reset = r; we = w; select = s;
    write_address = wa; read_address = ra; in_data = d;
    @(negedge clk);
  endtask

  function automatic logic [511:0] rand_half();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [511:0] lanes(input int re_base, input int im_base);
    logic [511:0] r;
    for (int k = 0; k < 8; k++) r[64*k +: 64] = {32'(re_base + k), 32'(im_base + k)};
    return r;
  endfunction

  logic [511:0] d1, d3, a2lo, a2hi, da, db, dc, dx, dx2, dy, dw, dz, dead, zero;

  initial begin
    reset = 1'b1; we = 1'b0; select = 1'b0;
    write_address = '0; read_address = '0; in_data = '0;
    zero = '0;
    d1   = {8{64'h11111111_22222222}};
    d3   = {8{64'h33333333_44444444}};
    dead = {16{32'hDEADBEEF}};
    a2lo = lanes(0, 100);
    a2hi = lanes(200, 300);
    da = rand_half(); db = rand_half(); dc = rand_half();
    dx = rand_half(); dx2 = rand_half(); dy = rand_half();
    dw = rand_half(); dz = rand_half();
    @(negedge clk);

    // 1: reset clears the output, then a full tile is written and read back
    step(1'b1, 1'b0, 1'b0, 9'd0, 9'd0, zero);
    lit("rst_lo_1", out_data[511:0], zero);
    lit("rst_hi_1", out_data[1023:512], zero);
    step(1'b1, 1'b0, 1'b0, 9'd0, 9'd0, zero);
    lit("rst_lo_2", out_data[511:0], zero);
    lit("rst_hi_2", out_data[1023:512], zero);
    step(1'b0, 1'b1, 1'b0, 9'd0, 9'd9, d1);
    step(1'b0, 1'b1, 1'b1, 9'd0, 9'd9, d3);
    step(1'b0, 1'b0, 1'b0, 9'd0, 9'd0, zero);
    lit("a0_lo", out_data[511:0], d1);
    lit("a0_hi", out_data[1023:512], d3);
    lit("a0_lane0", {448'd0, out_data[63:0]}, {448'd0, 64'h11111111_22222222});
    lit("a0_lane15", {448'd0, out_data[1023:960]}, {448'd0, 64'h33333333_44444444});

    // 2: per-lane distinct data at address 1; address 0 is unchanged
    step(1'b0, 1'b1, 1'b0, 9'd1, 9'd9, a2lo);
    step(1'b0, 1'b1, 1'b1, 9'd1, 9'd9, a2hi);
    step(1'b0, 1'b0, 1'b0, 9'd0, 9'd1, zero);
    lit("a1_lo", out_data[511:0], a2lo);
    lit("a1_hi", out_data[1023:512], a2hi);
    lit("a1_lane3", {448'd0, out_data[255:192]}, {448'd0, 32'd3, 32'd103});
    lit("a1_lane10", {448'd0, out_data[703:640]}, {448'd0, 32'd202, 32'd302});
    step(1'b0, 1'b0, 1'b0, 9'd0, 9'd0, zero);
    lit("a0_keep_lo", out_data[511:0], d1);
    lit("a0_keep_hi", out_data[1023:512], d3);

    // 3: repeated select=0 writes never disturb sub-bank 1
    step(1'b0, 1'b1, 1'b1, 9'd5, 9'd9, dc);
    step(1'b0, 1'b1, 1'b0, 9'd5, 9'd9, da);
    step(1'b0, 1'b1, 1'b0, 9'd5, 9'd9, db);
    step(1'b0, 1'b0, 1'b0, 9'd0, 9'd5, zero);
    lit("a5_lo", out_data[511:0], db);
    lit("a5_hi", out_data[1023:512], dc);

    // 4: we=0 leaves storage unchanged
    step(1'b0, 1'b0, 1'b0, 9'd0, 9'd7, dead);
    step(1'b0, 1'b0, 1'b1, 9'd0, 9'd0, dead);
    lit("we0_lo", out_data[511:0], d1);
    lit("we0_hi", out_data[1023:512], d3);

    // 5: same-address read during write
    step(1'b0, 1'b1, 1'b0, 9'd2, 9'd9, dx);
    step(1'b0, 1'b1, 1'b1, 9'd2, 9'd9, dx2);
    step(1'b0, 1'b1, 1'b0, 9'd2, 9'd2, dy);
`ifdef KERNEL_MEM_WR_BYPASS_EN
    lit("rdw_lo", out_data[511:0], dy);
`else
    lit("rdw_lo", out_data[511:0], dx);
`endif
    lit("rdw_hi", out_data[1023:512], dx2);
    step(1'b0, 1'b0, 1'b0, 9'd0, 9'd2, zero);
    lit("rdw_next_lo", out_data[511:0], dy);

    // 6: reset cancels an in-flight write; earlier contents survive reset
    step(1'b0, 1'b1, 1'b0, 9'd3, 9'd9, dw);
    step(1'b1, 1'b1, 1'b0, 9'd3, 9'd3, dz);
    lit("rst_wr_out", out_data[511:0], zero);
    step(1'b0, 1'b0, 1'b0, 9'd0, 9'd3, zero);
    lit("a3_kept", out_data[511:0], dw);
    step(1'b0, 1'b0, 1'b0, 9'd0, 9'd0, zero);
    lit("a0_post_rst_lo", out_data[511:0], d1);
    lit("a0_post_rst_hi", out_data[1023:512], d3);
    step(1'b0, 1'b0, 1'b0, 9'd0, 9'd1, zero);
    lit("a1_post_rst_lo", out_data[511:0], a2lo);
    lit("a1_post_rst_hi", out_data[1023:512], a2hi);

    // Random traffic: mostly a small address window to force collisions
    for (int n = 0; n < 3000; n++) begin
      logic [8:0] wa, ra;
      wa = ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'($urandom_range(0, 15));
      ra = ($urandom_range(0, 1) == 0) ? wa : 9'($urandom_range(0, 15));
      step(($urandom_range(0, 49) == 0), 1'($urandom), 1'($urandom), wa, ra, rand_half());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
